// File: rtl/ps2_device_port_if.sv
// Byte-level handshake between the PS/2 device port and its internal client.
interface ps2_device_port_if;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_abort;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;

    modport master (
        output tx_data, tx_load,
        input  tx_busy, tx_done, tx_abort, rx_data, rx_valid, rx_error
    );

    modport slave (
        input  tx_data, tx_load,
        output tx_busy, tx_done, tx_abort, rx_data, rx_valid, rx_error
    );
endinterface

// File: rtl/ps2_device_port.sv
// Device-side PS/2 port: generates the PS/2 clock, sends bytes to the host and
// receives host commands with acknowledge. Both lines are open-drain.
module ps2_device_port #(
    parameter int unsigned HALFPER   = 1120,
    parameter int unsigned IDLE_HOLD = 1400
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire              ps2clk_ext,
    inout  wire              ps2data_ext,
    ps2_device_port_if.slave bus
);
    localparam int unsigned PhW = $clog2(2 * HALFPER);
    localparam int unsigned IdW = $clog2(IDLE_HOLD + 1);
    localparam int unsigned RtW = $clog2(HALFPER + 1);
    localparam logic [PhW-1:0] PhHiEnd  = PhW'(HALFPER - 1);
    localparam logic [PhW-1:0] PhLoEnd  = PhW'(2 * HALFPER - 1);
    localparam logic [PhW-1:0] PhSample = PhW'(HALFPER / 2);

    typedef enum logic [2:0] {
        StIdle, StRxStart, StRxBit, StRxAck, StTxBit, StTxEnd
    } state_e;

    state_e         state_q;
    logic [PhW-1:0] phase_q;
    logic [3:0]     bit_q;
    logic           clk_s1_q, clk_s_q, dat_s1_q, dat_s_q;
    logic [IdW-1:0] idle_cnt_q;
    logic [RtW-1:0] rts_cnt_q;
    logic           clk_low_q, dat_low_q;
    logic           tx_pend_q, tx_par_q;
    logic [7:0]     tx_byte_q;
    logic [9:0]     rx_bits_q;
    logic [7:0]     rx_data_q;
    logic           tx_done_q, tx_abort_q, rx_valid_q, rx_error_q;
    logic [10:0]    tx_frame;

    assign ps2clk_ext  = clk_low_q ? 1'b0 : 1'bz;
    assign ps2data_ext = dat_low_q ? 1'b0 : 1'bz;

    // Index 0 is the start bit; the host sees bit k during the k-th clock.
    assign tx_frame = {1'b1, tx_par_q, tx_byte_q, 1'b0};

    assign bus.tx_busy  = tx_pend_q;
    assign bus.tx_done  = tx_done_q;
    assign bus.tx_abort = tx_abort_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_error = rx_error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s_q    <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s_q    <= 1'b1;
            idle_cnt_q <= '0;
        end else begin
            clk_s1_q <= ps2clk_ext;
            clk_s_q  <= clk_s1_q;
            dat_s1_q <= ps2data_ext;
            dat_s_q  <= dat_s1_q;
            if (!(clk_s_q && dat_s_q)) begin
                idle_cnt_q <= '0;
            end else if (idle_cnt_q != IdW'(IDLE_HOLD)) begin
                idle_cnt_q <= idle_cnt_q + IdW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            bit_q      <= '0;
            rts_cnt_q  <= '0;
            clk_low_q  <= 1'b0;
            dat_low_q  <= 1'b0;
            tx_pend_q  <= 1'b0;
            tx_par_q   <= 1'b0;
            tx_byte_q  <= '0;
            rx_bits_q  <= '0;
            rx_data_q  <= '0;
            tx_done_q  <= 1'b0;
            tx_abort_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            tx_done_q  <= 1'b0;
            tx_abort_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
            if (bus.tx_load && !tx_pend_q) begin
                tx_pend_q <= 1'b1;
                tx_byte_q <= bus.tx_data;
                tx_par_q  <= ~^bus.tx_data;
            end
            unique case (state_q)
                StIdle: begin
                    phase_q <= '0;
                    bit_q   <= '0;
                    // Host request-to-send wins over a pending transmit.
                    if (clk_s_q && !dat_s_q) begin
                        if (rts_cnt_q == RtW'(HALFPER - 1)) begin
                            rts_cnt_q <= '0;
                            state_q   <= StRxStart;
                        end else begin
                            rts_cnt_q <= rts_cnt_q + RtW'(1);
                        end
                    end else begin
                        rts_cnt_q <= '0;
                        if (tx_pend_q && idle_cnt_q == IdW'(IDLE_HOLD)) begin
                            state_q   <= StTxBit;
                            dat_low_q <= ~tx_frame[0];
                        end
                    end
                end
                StTxBit: begin
                    phase_q <= phase_q + PhW'(1);
                    if (phase_q == PhHiEnd) begin
                        if (!clk_s_q) begin
                            clk_low_q  <= 1'b0;
                            dat_low_q  <= 1'b0;
                            tx_abort_q <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            clk_low_q <= 1'b1;
                        end
                    end else if (phase_q == PhLoEnd) begin
                        phase_q   <= '0;
                        clk_low_q <= 1'b0;
                        if (bit_q == 4'd10) begin
                            dat_low_q <= 1'b0;
                            state_q   <= StTxEnd;
                        end else begin
                            bit_q     <= bit_q + 4'd1;
                            dat_low_q <= ~tx_frame[bit_q + 4'd1];
                        end
                    end
                end
                StTxEnd: begin
                    tx_done_q <= 1'b1;
                    tx_pend_q <= 1'b0;
                    state_q   <= StIdle;
                end
                StRxStart, StRxBit: begin
                    phase_q <= phase_q + PhW'(1);
                    if (state_q == StRxBit && phase_q == PhSample) begin
                        rx_bits_q[bit_q] <= dat_s_q;
                    end
                    if (phase_q == PhHiEnd) begin
                        if (!clk_s_q) begin
                            rx_error_q <= 1'b1;
                            state_q    <= StIdle;
                        end else if (state_q == StRxBit && bit_q == 4'd9) begin
                            // Stop bit gets no low phase; the ack clock follows directly.
                            if (!rx_bits_q[9]) begin
                                rx_error_q <= 1'b1;
                                state_q    <= StIdle;
                            end else begin
                                phase_q   <= '0;
                                dat_low_q <= 1'b1;
                                state_q   <= StRxAck;
                            end
                        end else begin
                            clk_low_q <= 1'b1;
                        end
                    end else if (phase_q == PhLoEnd) begin
                        phase_q   <= '0;
                        clk_low_q <= 1'b0;
                        if (state_q == StRxStart) begin
                            state_q <= StRxBit;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                end
                StRxAck: begin
                    phase_q <= phase_q + PhW'(1);
                    if (phase_q == PhHiEnd) begin
                        clk_low_q <= 1'b1;
                    end else if (phase_q == PhLoEnd) begin
                        clk_low_q <= 1'b0;
                        dat_low_q <= 1'b0;
                        state_q   <= StIdle;
                        if (^rx_bits_q[8:0]) begin
                            rx_data_q  <= rx_bits_q[7:0];
                            rx_valid_q <= 1'b1;
                        end else begin
                            rx_error_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_device_port.sv
// Self-checking bench for ps2_device_port: a behavioural PS/2 host with pull-ups
// plus a byte-level reference model of frames, parity and event counts.
module tb_ps2_device_port;
    localparam int unsigned HALFPER   = 20;
    localparam int unsigned IDLE_HOLD = 30;
    localparam time         TCLK      = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic host_clk_low = 1'b0;
    logic host_dat_low = 1'b0;
    wire  ps2clk, ps2data;

    always #5 clk = ~clk;

    pullup (ps2clk);
    pullup (ps2data);
    assign ps2clk  = host_clk_low ? 1'b0 : 1'bz;
    assign ps2data = host_dat_low ? 1'b0 : 1'bz;

    ps2_device_port_if bus ();

    ps2_device_port #(
        .HALFPER   (HALFPER),
        .IDLE_HOLD (IDLE_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2clk_ext  (ps2clk),
        .ps2data_ext (ps2data),
        .bus         (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0, n_abort = 0, n_valid = 0, n_error = 0, n_overlap = 0;
    logic [7:0] model_rx_data = 8'h00;

    // Device-generated falling edges, as the host would sample them.
    logic fall_bits[$];
    time  fall_t[$];

    always @(negedge ps2clk) begin
        if (!host_clk_low) begin
            fall_bits.push_back(ps2data);
            fall_t.push_back($time);
        end
    end

    always @(negedge clk) begin
        if (bus.tx_done  === 1'b1) n_done++;
        if (bus.tx_abort === 1'b1) n_abort++;
        if (bus.rx_valid === 1'b1) n_valid++;
        if (bus.rx_error === 1'b1) n_error++;
        if (int'(bus.tx_done === 1'b1) + int'(bus.tx_abort === 1'b1) +
            int'(bus.rx_valid === 1'b1) + int'(bus.rx_error === 1'b1) > 1) n_overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_tx_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9) return ~^d;
        return 1'b1;
    endfunction

    function automatic int ev_cnt(input int which);
        case (which)
            0:       return n_done;
            1:       return n_abort;
            2:       return n_valid;
            default: return n_error;
        endcase
    endfunction

    task automatic wait_ev(input int which, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ev_cnt(which) >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_falls(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fall_bits.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_falls();
        fall_bits.delete();
        fall_t.delete();
    endtask

    task automatic load_byte(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data = d;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d);
        logic [10:0] got, exp;
        int bad_gap;
        bad_gap = 0;
        got = '0;
        exp = '0;
        check_eq({tag, "_nfalls"}, fall_bits.size(), 11);
        for (int k = 0; k < 11; k++) begin
            exp[k] = exp_tx_bit(d, k);
            if (k < fall_bits.size()) got[k] = fall_bits[k];
        end
        for (int k = 1; k < fall_bits.size(); k++) begin
            if (fall_t[k] - fall_t[k-1] != 2 * HALFPER * TCLK) bad_gap++;
        end
        check_eq({tag, "_bits"}, got, exp);
        check_eq({tag, "_gaps"}, bad_gap, 0);
    endtask

    task automatic do_tx(input string tag, input logic [7:0] d);
        int base;
        bit ok;
        clear_falls();
        base = n_done;
        load_byte(d);
        check_eq({tag, "_busy"}, bus.tx_busy, 1);
        wait_ev(0, base + 1, 3000, ok);
        check_eq({tag, "_done_seen"}, ok, 1);
        repeat (3) @(negedge clk);
        check_eq({tag, "_done_cnt"}, n_done - base, 1);
        check_eq({tag, "_busy_after"}, bus.tx_busy, 0);
        check_frame(tag, d);
    endtask

    // Host request-to-send followed by one command byte, clocked by the device.
    task automatic host_send(input logic [7:0] d, input logic par, input bit with_load,
                             input logic [7:0] load_d, output int misses);
        bit ok;
        misses = 0;
        clear_falls();
        @(negedge clk);
        host_clk_low = 1'b1;
        if (with_load) begin
            bus.tx_data = load_d;
            bus.tx_load = 1'b1;
        end
        @(negedge clk);
        bus.tx_load = 1'b0;
        repeat (4) @(negedge clk);
        host_dat_low = 1'b1;
        repeat (55) @(negedge clk);
        host_clk_low = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            wait_falls(k, 200, ok);
            if (!ok) misses++;
            if (k <= 8)      host_dat_low = ~d[k-1];
            else if (k == 9) host_dat_low = ~par;
            else             host_dat_low = 1'b0;
        end
        wait_falls(11, 200, ok);
        if (!ok) misses++;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ps2clk === 1'b1 && ps2data === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) misses++;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_rx(input string tag, input logic [7:0] d, input logic par,
                         input bit with_load, input logic [7:0] load_d);
        int base_v, base_e, misses;
        logic good, ack;
        base_v = n_valid;
        base_e = n_error;
        host_send(d, par, with_load, load_d, misses);
        good = ^{d, par};
        if (good) model_rx_data = d;
        ack = (fall_bits.size() >= 11) ? fall_bits[10] : 1'b1;
        check_eq({tag, "_timeouts"}, misses, 0);
        check_eq({tag, "_nclocks"}, fall_bits.size(), 11);
        check_eq({tag, "_ack_low"}, ack, 0);
        check_eq({tag, "_valid"}, n_valid - base_v, good ? 1 : 0);
        check_eq({tag, "_error"}, n_error - base_e, good ? 0 : 1);
        check_eq({tag, "_rx_data"}, bus.rx_data, model_rx_data);
    endtask

    initial begin
        bit ok;
        int base_d, base_a;
        logic [7:0] r;

        bus.tx_data = 8'h00;
        bus.tx_load = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("reset_busy", bus.tx_busy, 0);
        check_eq("reset_pulses", {bus.tx_done, bus.tx_abort, bus.rx_valid, bus.rx_error}, 0);
        check_eq("reset_rx_data", bus.rx_data, 8'h00);
        check_eq("reset_lines", {ps2clk, ps2data}, 2'b11);
        repeat (40) @(negedge clk);

        do_tx("tx_1c", 8'h1C);

        // Host inhibits after the 4th falling edge, then lets the retry through.
        clear_falls();
        base_d = n_done;
        base_a = n_abort;
        load_byte(8'h5A);
        wait_falls(4, 1000, ok);
        check_eq("abort_4falls", ok, 1);
        host_clk_low = 1'b1;
        wait_ev(1, base_a + 1, 200, ok);
        check_eq("abort_seen", ok, 1);
        repeat (3) @(negedge clk);
        check_eq("abort_data_released", ps2data, 1);
        check_eq("abort_busy_kept", bus.tx_busy, 1);
        repeat (100) @(negedge clk);
        check_eq("abort_no_done", n_done - base_d, 0);
        clear_falls();
        host_clk_low = 1'b0;
        wait_ev(0, base_d + 1, 3000, ok);
        check_eq("retx_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        check_eq("abort_cnt", n_abort - base_a, 1);
        check_frame("retx_5a", 8'h5A);

        do_rx("rx_ff", 8'hFF, ~^8'hFF, 1'b0, 8'h00);
        do_rx("rx_ed_badpar", 8'hED, ^8'hED, 1'b0, 8'h00);

        // Load and request-to-send in the same cycle: command first, then the byte.
        base_d = n_done;
        do_rx("rx_f4", 8'hF4, ~^8'hF4, 1'b1, 8'hAA);
        check_eq("aa_not_before_rx", n_done - base_d, 0);
        check_eq("aa_busy_held", bus.tx_busy, 1);
        clear_falls();
        wait_ev(0, base_d + 1, 3000, ok);
        check_eq("aa_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        check_frame("tx_aa", 8'hAA);

        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom_range(0, 255));
            do_tx("rand_tx", r);
            r = 8'($urandom_range(0, 255));
            do_rx("rand_rx", r, ($urandom_range(0, 1) == 1) ? ~^r : ^r, 1'b0, 8'h00);
        end

        // Reset in the low phase of bit 4 while data is driven low (d[3] = 0).
        repeat (40) @(negedge clk);
        clear_falls();
        base_d = n_done;
        base_a = n_abort;
        r = 8'($urandom_range(0, 255)) & 8'hF7;
        load_byte(r);
        wait_falls(5, 1000, ok);
        check_eq("rst_5falls", ok, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_lines_released", {ps2clk, ps2data}, 2'b11);
        check_eq("rst_busy", bus.tx_busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (800) @(negedge clk);
        check_eq("rst_no_done_abort", (n_done - base_d) + (n_abort - base_a), 0);
        check_eq("rst_no_retx", fall_bits.size(), 5);
        check_eq("rst_busy_after", bus.tx_busy, 0);

        check_eq("pulse_overlap", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
